// File: rtl/id_witf_ctrl.sv
// Decode-stage issue control with a write-in-flight table (WITF) for RAW stall detection.
// Optional macro WITF_BYPASS_EN: a retiring entry stops hitting, and a full table may push while popping.
module id_witf_ctrl #(
  parameter int XLEN       = 64,
  parameter int WITF_DEPTH = 4,
  parameter int RADDR_W    = 5
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        id_valid,
  output logic                        id_ready,
  input  logic [31:0]                 id_inst,
  input  logic [XLEN-1:0]             id_pc,
  input  logic                        reg_wr,
  input  logic                        rs1_used,
  input  logic                        rs2_used,
  input  logic                        pipeline_flush,
  input  logic                        exu_allow_in,
  output logic                        id_to_exu_valid,
  input  logic                        wb_retire,
  output logic [RADDR_W-1:0]          rs1,
  output logic [RADDR_W-1:0]          rs2,
  output logic [RADDR_W-1:0]          rd,
  output logic [31:0]                 inst_o,
  output logic [XLEN-1:0]             pc_o,
  output logic                        is_raw,
  output logic                        witf_full,
  output logic [$clog2(WITF_DEPTH):0] witf_count,
  output logic                        witf_err
);

  localparam int PTR_W = $clog2(WITF_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WITF_DEPTH-1:0] r_valid;
  logic [RADDR_W-1:0]    r_rd [WITF_DEPTH];
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [CNT_W-1:0]      r_count;
  logic                  r_err;

  logic w_pop;
  logic w_push;
  logic w_ready_go;
  logic w_hit1;
  logic w_hit2;
  logic w_full;

  assign rs1    = id_inst[15 +: RADDR_W];
  assign rs2    = id_inst[20 +: RADDR_W];
  assign rd     = id_inst[7 +: RADDR_W];
  assign inst_o = id_inst;
  assign pc_o   = id_pc;

  assign w_pop = wb_retire & (r_count != '0);

`ifdef WITF_BYPASS_EN
  assign w_full = (r_count == CNT_W'(WITF_DEPTH)) & ~w_pop;
`else
  assign w_full = (r_count == CNT_W'(WITF_DEPTH));
`endif

  // Associative match of both source indices against every live entry
  always_comb begin
    w_hit1 = 1'b0;
    w_hit2 = 1'b0;
    for (int i = 0; i < WITF_DEPTH; i++) begin
`ifdef WITF_BYPASS_EN
      w_hit1 = w_hit1 | (r_valid[i] & (r_rd[i] == rs1) & ~(w_pop & (PTR_W'(i) == r_rd_ptr)));
      w_hit2 = w_hit2 | (r_valid[i] & (r_rd[i] == rs2) & ~(w_pop & (PTR_W'(i) == r_rd_ptr)));
`else
      w_hit1 = w_hit1 | (r_valid[i] & (r_rd[i] == rs1));
      w_hit2 = w_hit2 | (r_valid[i] & (r_rd[i] == rs2));
`endif
    end
  end

  assign is_raw          = id_valid & ((rs1_used & (rs1 != '0) & w_hit1) |
                                       (rs2_used & (rs2 != '0) & w_hit2));
  assign w_ready_go      = ~w_full & ~is_raw;
  assign id_ready        = ~id_valid | (w_ready_go & exu_allow_in);
  assign id_to_exu_valid = id_valid & w_ready_go & ~pipeline_flush;
  assign w_push          = id_to_exu_valid & exu_allow_in & reg_wr & (rd != '0);

  assign witf_full  = w_full;
  assign witf_count = r_count;
  assign witf_err   = r_err;

  // Table state; pop is applied before push so a full-table push+pop on one slot leaves it valid
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_valid  <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_err    <= 1'b0;
      for (int i = 0; i < WITF_DEPTH; i++) begin
        r_rd[i] <= '0;
      end
    end else begin
      if (w_pop) begin
        r_valid[r_rd_ptr] <= 1'b0;
        r_rd_ptr          <= r_rd_ptr + PTR_W'(1);
      end
      if (w_push) begin
        r_valid[r_wr_ptr] <= 1'b1;
        r_rd[r_wr_ptr]    <= rd;
        r_wr_ptr          <= r_wr_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
      if (wb_retire && (r_count == '0)) begin
        r_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_id_witf_ctrl.sv
// Self-checking bench for id_witf_ctrl: directed scenarios plus randomized traffic
// compared against a queue-based model of the in-flight write table.
module tb_id_witf_ctrl;
  localparam int XLEN  = 64;
  localparam int DEPTH = 4;
  localparam int RW    = 5;
`ifdef WITF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic            id_valid, id_ready;
  logic [31:0]     id_inst;
  logic [XLEN-1:0] id_pc;
  logic            reg_wr, rs1_used, rs2_used, pipeline_flush, exu_allow_in;
  logic            id_to_exu_valid, wb_retire;
  logic [RW-1:0]   rs1, rs2, rd;
  logic [31:0]     inst_o;
  logic [XLEN-1:0] pc_o;
  logic            is_raw, witf_full, witf_err;
  logic [2:0]      witf_count;

  int n_vec = 0;
  int n_err = 0;

  logic [4:0] mq[$];
  bit         m_err = 1'b0;
  bit         e_pop, e_full, e_raw, e_ready, e_v, e_push;

  id_witf_ctrl #(.XLEN(XLEN), .WITF_DEPTH(DEPTH), .RADDR_W(RW)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_ready(id_ready),
    .id_inst(id_inst), .id_pc(id_pc), .reg_wr(reg_wr), .rs1_used(rs1_used),
    .rs2_used(rs2_used), .pipeline_flush(pipeline_flush), .exu_allow_in(exu_allow_in),
    .id_to_exu_valid(id_to_exu_valid), .wb_retire(wb_retire),
    .rs1(rs1), .rs2(rs2), .rd(rd), .inst_o(inst_o), .pc_o(pc_o),
    .is_raw(is_raw), .witf_full(witf_full), .witf_count(witf_count), .witf_err(witf_err)
  );

  always #5 clk = ~clk;

  task automatic set_in(input bit v, input logic [4:0] d, input logic [4:0] s1,
                        input logic [4:0] s2, input bit wr, input bit u1, input bit u2,
                        input bit fl, input bit al, input bit ret);
    id_valid       = v;
    id_inst        = {7'd0, s2, s1, 3'd0, d, 7'h33};
    id_pc          = {$urandom, $urandom};
    reg_wr         = wr;
    rs1_used       = u1;
    rs2_used       = u2;
    pipeline_flush = fl;
    exu_allow_in   = al;
    wb_retire      = ret;
    #1;
  endtask

  function automatic bit m_hit(input logic [4:0] r, input bit pop);
    for (int k = 0; k < mq.size(); k++) begin
      if (!(BYP && pop && k == 0) && mq[k] == r) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic model_eval();
    logic [4:0] s1, s2, d;
    s1 = id_inst[19:15];
    s2 = id_inst[24:20];
    d  = id_inst[11:7];
    e_pop   = wb_retire && (mq.size() != 0);
    e_full  = (mq.size() == DEPTH) && !(BYP && e_pop);
    e_raw   = id_valid && ((rs1_used && s1 != 5'd0 && m_hit(s1, e_pop)) ||
                           (rs2_used && s2 != 5'd0 && m_hit(s2, e_pop)));
    e_ready = !id_valid || (!e_full && !e_raw && exu_allow_in);
    e_v     = id_valid && !e_full && !e_raw && !pipeline_flush;
    e_push  = e_v && exu_allow_in && reg_wr && d != 5'd0;
  endtask

  task automatic tick();
    model_eval();
    @(posedge clk);
    if (!rst) begin
      mq.delete();
      m_err = 1'b0;
    end else begin
      if (wb_retire && !e_pop) m_err = 1'b1;
      if (e_pop) void'(mq.pop_front());
      if (e_push) mq.push_back(id_inst[11:7]);
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    set_in(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 1, 0);
    tick();
    tick();
    rst = 1'b1;
    #1;
    n_vec++;
    if (witf_count !== 3'd0) begin n_err++; $display("FAIL reset_count got %0d want 0", witf_count); end
    n_vec++;
    if ({witf_full, witf_err, id_ready} !== 3'b001) begin
      n_err++; $display("FAIL reset_flags got %b want 001", {witf_full, witf_err, id_ready});
    end
  endtask

  task automatic test_fill_full();
    for (int i = 0; i < 4; i++) begin
      set_in(1, 5'(5 + i), 5'd0, 5'd0, 1, 0, 0, 0, 1, 0);
      n_vec++;
      if (id_to_exu_valid !== 1'b1) begin n_err++; $display("FAIL fill_dispatch%0d got %b want 1", i, id_to_exu_valid); end
      tick();
    end
    n_vec++;
    if ({witf_full, witf_count} !== 4'b1100) begin
      n_err++; $display("FAIL fill_full got full=%b cnt=%0d want full=1 cnt=4", witf_full, witf_count);
    end
    set_in(1, 5'd9, 5'd0, 5'd0, 1, 0, 0, 0, 1, 0);
    n_vec++;
    if ({id_ready, id_to_exu_valid} !== 2'b00) begin
      n_err++; $display("FAIL full_block got ready/valid=%b want 00", {id_ready, id_to_exu_valid});
    end
    tick();
    for (int i = 0; i < 4; i++) begin
      set_in(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 1, 1);
      tick();
    end
    n_vec++;
    if ({witf_full, witf_count} !== 4'b0000) begin
      n_err++; $display("FAIL drain got full=%b cnt=%0d want 0/0", witf_full, witf_count);
    end
  endtask

  task automatic test_raw_stall();
    set_in(1, 5'd5, 5'd0, 5'd0, 1, 0, 0, 0, 1, 0);
    tick();
    set_in(1, 5'd0, 5'd5, 5'd0, 0, 1, 0, 0, 1, 0);
    n_vec++;
    if ({is_raw, id_to_exu_valid, id_ready} !== 3'b100) begin
      n_err++; $display("FAIL raw_stall got raw/valid/ready=%b want 100", {is_raw, id_to_exu_valid, id_ready});
    end
    tick();
    set_in(1, 5'd0, 5'd5, 5'd0, 0, 1, 0, 0, 1, 1);
    n_vec++;
    if ({is_raw, id_to_exu_valid} !== {!BYP, BYP}) begin
      n_err++; $display("FAIL raw_retire got raw/valid=%b want %b", {is_raw, id_to_exu_valid}, {!BYP, BYP});
    end
    tick();
    set_in(1, 5'd0, 5'd5, 5'd0, 0, 1, 0, 0, 1, 0);
    n_vec++;
    if ({is_raw, id_to_exu_valid, witf_count} !== 5'b01000) begin
      n_err++; $display("FAIL raw_release got raw=%b valid=%b cnt=%0d want 0 1 0", is_raw, id_to_exu_valid, witf_count);
    end
    tick();
  endtask

  task automatic test_x0();
    set_in(1, 5'd0, 5'd0, 5'd0, 1, 0, 0, 0, 1, 0);
    n_vec++;
    if (id_to_exu_valid !== 1'b1) begin n_err++; $display("FAIL x0_dispatch got %b want 1", id_to_exu_valid); end
    tick();
    n_vec++;
    if (witf_count !== 3'd0) begin n_err++; $display("FAIL x0_count got %0d want 0", witf_count); end
    set_in(1, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 1, 0);
    n_vec++;
    if (is_raw !== 1'b0) begin n_err++; $display("FAIL x0_raw got %b want 0", is_raw); end
  endtask

  task automatic test_flush();
    set_in(1, 5'd1, 5'd0, 5'd0, 1, 0, 0, 0, 1, 0);
    tick();
    set_in(1, 5'd2, 5'd0, 5'd0, 1, 0, 0, 0, 1, 0);
    tick();
    set_in(1, 5'd3, 5'd0, 5'd0, 1, 0, 0, 1, 1, 0);
    n_vec++;
    if (id_to_exu_valid !== 1'b0) begin n_err++; $display("FAIL flush_valid got %b want 0", id_to_exu_valid); end
    tick();
    n_vec++;
    if (witf_count !== 3'd2) begin n_err++; $display("FAIL flush_count got %0d want 2", witf_count); end
    set_in(1, 5'd0, 5'd3, 5'd2, 0, 1, 1, 0, 1, 0);
    n_vec++;
    if (is_raw !== 1'b1) begin n_err++; $display("FAIL flush_hit_x2 got %b want 1", is_raw); end
    set_in(1, 5'd0, 5'd3, 5'd0, 0, 1, 0, 0, 1, 0);
    n_vec++;
    if (is_raw !== 1'b0) begin n_err++; $display("FAIL flush_nohit_x3 got %b want 0", is_raw); end
  endtask

  task automatic test_push_pop_wrap();
    set_in(1, 5'd10, 5'd0, 5'd0, 1, 0, 0, 0, 1, 1);
    n_vec++;
    if (id_to_exu_valid !== 1'b1) begin n_err++; $display("FAIL pp_dispatch got %b want 1", id_to_exu_valid); end
    tick();
    n_vec++;
    if (witf_count !== 3'd2) begin n_err++; $display("FAIL pp_count got %0d want 2", witf_count); end
    for (int i = 0; i < 9; i++) begin
      set_in(1, 5'd0, 5'(10 + i), 5'd0, 0, 1, 0, 0, 1, 0);
      n_vec++;
      if (is_raw !== 1'b1) begin n_err++; $display("FAIL wrap_hit%0d got %b want 1", i, is_raw); end
      set_in(1, 5'(11 + i), 5'd0, 5'd0, 1, 0, 0, 0, 1, 1);
      tick();
      n_vec++;
      if (witf_count !== 3'd2) begin n_err++; $display("FAIL wrap_count%0d got %0d want 2", i, witf_count); end
    end
    set_in(1, 5'd0, 5'd17, 5'd0, 0, 1, 0, 0, 1, 0);
    n_vec++;
    if (is_raw !== 1'b0) begin n_err++; $display("FAIL wrap_stale got %b want 0", is_raw); end
    set_in(1, 5'd0, 5'd0, 5'd18, 0, 0, 1, 0, 1, 0);
    n_vec++;
    if (is_raw !== 1'b1) begin n_err++; $display("FAIL wrap_live got %b want 1", is_raw); end
    for (int i = 0; i < 2; i++) begin
      set_in(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 1, 1);
      tick();
    end
  endtask

  task automatic test_err_midreset();
    set_in(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 1, 1);
    tick();
    n_vec++;
    if ({witf_err, witf_count} !== 4'b1000) begin
      n_err++; $display("FAIL err_set got err=%b cnt=%0d want 1/0", witf_err, witf_count);
    end
    for (int i = 0; i < 3; i++) begin
      set_in(1, 5'(20 + i), 5'd0, 5'd0, 1, 0, 0, 0, 1, 0);
      tick();
    end
    n_vec++;
    if ({witf_err, witf_count} !== 4'b1011) begin
      n_err++; $display("FAIL err_sticky got err=%b cnt=%0d want 1/3", witf_err, witf_count);
    end
    rst = 1'b0;
    set_in(1, 5'd23, 5'd20, 5'd0, 1, 1, 0, 0, 1, 0);
    tick();
    rst = 1'b1;
    set_in(1, 5'd0, 5'd20, 5'd0, 0, 1, 0, 0, 1, 0);
    n_vec++;
    if ({witf_count, witf_err, is_raw} !== 5'b00000) begin
      n_err++; $display("FAIL midreset got cnt=%0d err=%b raw=%b want 0 0 0", witf_count, witf_err, is_raw);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      rst = ($urandom_range(63) != 0);
      set_in($urandom_range(3) != 0, 5'($urandom_range(7)), 5'($urandom_range(7)),
             5'($urandom_range(7)), $urandom_range(1) == 1, $urandom_range(1) == 1,
             $urandom_range(1) == 1, $urandom_range(7) == 0, $urandom_range(3) != 0,
             $urandom_range(2) == 0);
      model_eval();
      n_vec++;
      if ({is_raw, id_ready, id_to_exu_valid, witf_full, witf_count, witf_err} !==
          {e_raw, e_ready, e_v, e_full, 3'(mq.size()), m_err}) begin
        n_err++;
        $display("FAIL rand%0d got raw/rdy/v/full/cnt/err=%b want %b", c,
                 {is_raw, id_ready, id_to_exu_valid, witf_full, witf_count, witf_err},
                 {e_raw, e_ready, e_v, e_full, 3'(mq.size()), m_err});
      end
      n_vec++;
      if ({rs1, rs2, rd, inst_o, pc_o} !== {id_inst[19:15], id_inst[24:20], id_inst[11:7], id_inst, id_pc}) begin
        n_err++; $display("FAIL rand_pass%0d got inst_o=%h pc_o=%h want %h %h", c, inst_o, pc_o, id_inst, id_pc);
      end
      tick();
    end
    rst = 1'b1;
  endtask

  initial begin
    test_reset();
    test_fill_full();
    test_raw_stall();
    test_x0();
    test_flush();
    test_push_pop_wrap();
    test_err_midreset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/id_witf_ctrl.md
Name: id_witf_ctrl

Overview:
- Issue-control core of the decode stage, with an integrated write-in-flight table (WITF) of parametrised depth.
- Tracks destination registers of instructions dispatched to EXU but not yet written back.
- Raises RAW stalls against all in-flight entries and generates the IFU→ID and ID→EXU valid/ready handshakes.
- Sits between the IFU pipeline register and the EXU. Decode control signals come from the existing control generator.

Parameters:
- XLEN, 64, width of pc and register data.
- WITF_DEPTH, 4, number of in-flight write entries (power of two, ≥2).
- RADDR_W, 5, register index width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-low reset
- id_valid  in  1  IFU→ID instruction valid
- id_ready  out  1  ID can accept / advance
- id_inst  in  32  instruction
- id_pc  in  XLEN  instruction pc
- reg_wr  in  1  decoded: instruction writes rd
- rs1_used  in  1  decoded: instruction reads rs1
- rs2_used  in  1  decoded: instruction reads rs2
- pipeline_flush  in  1  EXU redirect; kill the instruction currently in ID
- exu_allow_in  in  1  EXU can accept
- id_to_exu_valid  out  1  ID→EXU valid
- wb_retire  in  1  oldest in-flight write completed this cycle
- rs1, rs2, rd  out  RADDR_W  each; inst[19:15], inst[24:20], inst[11:7]
- inst_o  out  32  pass-through of id_inst
- pc_o  out  XLEN  pass-through of id_pc
- is_raw  out  1  RAW hazard present
- witf_full  out  1  count == WITF_DEPTH
- witf_count  out  clog2(WITF_DEPTH)+1  occupancy
- witf_err  out  1  sticky: retire while empty

Behaviour:
- Reset: rst low at a clk edge clears all entry valids, wr_ptr, rd_ptr, count and witf_err. Reset overrides push/pop in the same cycle.
- WITF is a circular FIFO of {valid, rd}.
  - wr_ptr and rd_ptr wrap modulo WITF_DEPTH.
  - count is held separately and distinguishes full from empty.
- is_raw = id_valid & ((rs1_used & rs1≠0 & hit(rs1)) | (rs2_used & rs2≠0 & hit(rs2))).
  - hit(r) is true when any valid entry has rd == r.
- ready_go = !witf_full & !is_raw.
- id_ready = !id_valid | (ready_go & exu_allow_in).
- id_to_exu_valid = id_valid & ready_go & !pipeline_flush.
- push (dispatch) = id_to_exu_valid & exu_allow_in & reg_wr & rd≠0.
  - Writes {1, rd} at wr_ptr; wr_ptr advances one cycle later (registered).
  - rd = x0 is never recorded.
- pop = wb_retire & count≠0.
  - Clears the entry at rd_ptr and advances rd_ptr.
- Simultaneous push and pop: both apply and count is unchanged.
- Full: no push occurs, even if a pop happens in the same cycle (conservative). Dispatch resumes the next cycle.
- wb_retire while empty: ignored; witf_err set (sticky until reset).
- pipeline_flush: suppresses id_to_exu_valid and push. It does not clear the WITF, because older dispatched instructions still write back.
- Latency:
  - Hazard detection is combinational.
  - A newly pushed entry is visible to is_raw from the next cycle.
  - An instruction stalled by RAW dispatches in the cycle after the matching pop (without the optional feature).
- Pass-through outputs are combinational. rs1/rs2/rd are driven regardless of id_valid.

Optional Feature:
- Macro WITF_BYPASS_EN.
- When defined: during a cycle with pop, the entry at rd_ptr is excluded from hit(). A RAW stall then releases in the same cycle as the retire (WB→read forwarding assumed at the register file). witf_full is also computed as count==WITF_DEPTH & !pop, which allows push-with-pop when full.
- When undefined: behaviour exactly as above.

Test Plan:
- Reset, then dispatch 4 instructions writing x5, x6, x7, x8 with exu_allow_in=1 → witf_count=4 and witf_full=1. A 5th valid instruction (rd=x9, no sources) → id_ready=0, id_to_exu_valid=0.
- Dispatch write to x5, then an instruction reading rs1=x5 → is_raw=1 and stalled. Pulse wb_retire → dispatches next cycle (same cycle with WITF_BYPASS_EN); count returns to 0.
- Instruction with rd=x0 and reg_wr=1 dispatched → witf_count unchanged at 0. Instruction reading rs2=x0 → is_raw=0.
- pipeline_flush=1 with id_valid=1, reg_wr=1, rd=x3 → id_to_exu_valid=0, no push. Entries pushed earlier for x1 and x2 are still present (count=2).
- Push and pop in the same cycle at count=2 → count stays 2. Run 9 push/pop pairs with DEPTH=4 → pointers wrap and hit() still matches the correct rd.
- wb_retire at count=0 → witf_err=1 and stays 1 after further traffic. rst low for one cycle mid-operation (count=3) → count=0, witf_err=0, is_raw=0.
